// File: rtl/mux_rr_sched_if.sv
// Handshake bundle between the requesters and the round-robin 4:1 mux scheduler.
// The master side drives req; the slave (scheduler) drives the mux controls and status.
interface mux_rr_sched_if;
  logic [3:0] req;
  logic       G;
  logic       A;
  logic       B;
  logic [3:0] grant;
  logic       busy;
  logic       done;

  modport master (output req, input G, A, B, grant, busy, done);
  modport slave  (input req, output G, A, B, grant, busy, done);
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for a shared 4:1 mux with strobe G (active low enable).
// Select lines only move while G is high, and every output comes straight from a flop.
module mux_rr_sched #(
  parameter int BURST_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  mux_rr_sched_if.slave       bus,
  output logic [1:0]          o_dbg_state,
  output logic [1:0]          o_dbg_ptr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic       r_g, w_g_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic [1:0] w_win;

  // Scan from ptr+3 down to ptr so the index closest to ptr is the last one written.
  always_comb begin
    w_win = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[2'(r_ptr + 2'(k))]) w_win = 2'(r_ptr + 2'(k));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_g_nxt     = r_g;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_g_nxt     = 1'b1;
        w_grant_nxt = 4'b0000;
        if (bus.req != 4'b0000) begin
          w_state_nxt = S_SETUP;
          w_sel_nxt   = w_win;
          w_grant_nxt = 4'(4'b0001 << w_win);
        end
      end
      S_SETUP: begin
        w_state_nxt = S_XFER;
        w_g_nxt     = 1'b0;
        w_cnt_nxt   = 8'd0;
      end
      S_XFER: begin
        // Full burst and requester withdrawal share one exit path.
        if ((r_cnt == LAST_CNT) || !bus.req[r_sel]) begin
          w_state_nxt = S_RELEASE;
          w_g_nxt     = 1'b1;
          w_grant_nxt = 4'b0000;
          w_done_nxt  = 1'b1;
          w_ptr_nxt   = 2'(r_sel + 2'd1);
        end else begin
          w_cnt_nxt = 8'(r_cnt + 8'd1);
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_g_nxt     = 1'b1;
        w_grant_nxt = 4'b0000;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
      r_sel   <= 2'd0;
      r_grant <= 4'b0000;
      r_g     <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_g     <= w_g_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.G       = r_g;
  assign bus.A       = r_sel[0];
  assign bus.B       = r_sel[1];
  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: two instances (BURST_LEN 8 and 1) share req/reset and are
// compared every cycle against a burst-level reference model.
module tb_mux_rr_sched;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  always #5 clk = ~clk;

  mux_rr_sched_if if8 ();
  mux_rr_sched_if if1 ();
  assign if8.req = req;
  assign if1.req = req;

  logic [1:0] st8, st1, ptr8, ptr1;

  mux_rr_sched #(.BURST_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .bus(if8.slave), .o_dbg_state(st8), .o_dbg_ptr(ptr8)
  );
  mux_rr_sched #(.BURST_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .o_dbg_state(st1), .o_dbg_ptr(ptr1)
  );

  logic       d_g[2];
  logic [1:0] d_sel[2];
  logic [3:0] d_grant[2];
  logic       d_busy[2];
  logic       d_done[2];
  logic [1:0] d_ptr[2];
  assign d_g[0] = if8.G;        assign d_g[1] = if1.G;
  assign d_sel[0] = {if8.B, if8.A};  assign d_sel[1] = {if1.B, if1.A};
  assign d_grant[0] = if8.grant; assign d_grant[1] = if1.grant;
  assign d_busy[0] = if8.busy;  assign d_busy[1] = if1.busy;
  assign d_done[0] = if8.done;  assign d_done[1] = if1.done;
  assign d_ptr[0] = ptr8;       assign d_ptr[1] = ptr1;

  // scoreboard counters and checking task
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: a burst is "owner + number of transfer cycles seen so far";
  // age 0 is the settle cycle, ages 1..N are the cycles with the mux enabled.
  int bl[2]      = '{8, 1};
  int m_owner[2] = '{-1, -1};
  int m_age[2]   = '{0, 0};
  bit m_rel[2]   = '{1'b0, 1'b0};
  int m_ptr[2]   = '{0, 0};
  int m_sel[2]   = '{0, 0};

  task automatic model_step(input int k);
    bit found;
    int idx;
    if (reset) begin
      m_owner[k] = -1; m_age[k] = 0; m_rel[k] = 1'b0; m_ptr[k] = 0; m_sel[k] = 0;
    end else if (m_rel[k]) begin
      m_rel[k] = 1'b0;
    end else if (m_owner[k] < 0) begin
      found = 1'b0;
      for (int j = 0; j < 4; j++) begin
        idx = (m_ptr[k] + j) % 4;
        if (!found && req[idx]) begin
          found = 1'b1; m_owner[k] = idx; m_sel[k] = idx; m_age[k] = 0;
        end
      end
    end else if (m_age[k] == 0) begin
      m_age[k] = 1;
    end else if (m_age[k] == bl[k] || !req[m_owner[k]]) begin
      m_ptr[k] = (m_owner[k] + 1) % 4;
      m_owner[k] = -1;
      m_rel[k] = 1'b1;
    end else begin
      m_age[k]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  logic [1:0] prev_sel[2];
  bit         prev_ok = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic       e_g;
      logic [3:0] e_grant;
      e_g     = (m_owner[k] >= 0 && m_age[k] >= 1) ? 1'b0 : 1'b1;
      e_grant = (m_owner[k] >= 0) ? 4'(4'b0001 << m_owner[k]) : 4'b0000;
      chk($sformatf("G[%0d]", k),     16'(d_g[k]),     16'(e_g));
      chk($sformatf("sel[%0d]", k),   16'(d_sel[k]),   16'(m_sel[k]));
      chk($sformatf("grant[%0d]", k), 16'(d_grant[k]), 16'(e_grant));
      chk($sformatf("busy[%0d]", k),  16'(d_busy[k]),  16'((m_owner[k] >= 0) || m_rel[k]));
      chk($sformatf("done[%0d]", k),  16'(d_done[k]),  16'(m_rel[k]));
      chk($sformatf("ptr[%0d]", k),   16'(d_ptr[k]),   16'(m_ptr[k]));
      if (prev_ok && d_g[k] === 1'b0)
        chk($sformatf("bbm[%0d]", k), 16'(d_sel[k]), 16'(prev_sel[k]));
      prev_sel[k] = d_sel[k];
    end
    prev_ok = 1'b1;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_g_low();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if8.G !== 1'b0 && n < 60);
    if (if8.G !== 1'b0) chk("g_low_timeout", 16'(if8.G), 16'd0);
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    // single requester held: full bursts to requester 0 back to back
    req = 4'b0001; tick(30);
    // all requesting: rotation 0,1,2,3,0...
    req = 4'b1111; tick(60);
    req = 4'b0000; tick(4);
    // early release of requester 2 after four enabled cycles
    req = 4'b0100;
    wait_g_low();
    tick(3);
    req = 4'b0000; tick(4);
    // reset in the middle of a transfer, then requester 3 alone
    req = 4'b0001;
    wait_g_low();
    tick(5);
    reset = 1'b1; tick(1);
    reset = 1'b0; req = 4'b1000; tick(20);
    // random traffic with occasional resets
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0; req = 4'b0000; tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
